// File: rtl/itch_feed_arb.sv
// itch_feed_arb: packet-atomic round-robin merge of N_PORTS Avalon-ST ITCH
// feeds onto one 64-bit stream for itch_parser. A port wins the grant only with
// a start-of-packet beat and keeps it until its end-of-packet beat is accepted
// downstream. Non-SOP beats seen while idle are drained and counted.
// Optional per-port packet counters: define ITCH_FEED_ARB_PKT_CNT_EN.
module itch_feed_arb #(
  parameter int N_PORTS  = 2,
  parameter int STREAM_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           s_valid,
  output logic [N_PORTS-1:0]           s_ready,
  input  logic [N_PORTS*STREAM_W-1:0]  s_data,
  input  logic [N_PORTS-1:0]           s_sop,
  input  logic [N_PORTS-1:0]           s_eop,
  input  logic [N_PORTS*3-1:0]         s_empty,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [STREAM_W-1:0]          m_data,
  output logic                         m_sop,
  output logic                         m_eop,
  output logic [2:0]                   m_empty,
  output logic [N_PORTS-1:0]           grant_oh,
  output logic                         busy,
  output logic [15:0]                  drop_cnt,
  output logic [N_PORTS*32-1:0]        pkt_cnt
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(N_PORTS + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_PORTS - 1);
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_PORTS);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state, state_nxt;
  logic [N_PORTS-1:0]  grant_nxt;
  logic [PTR_W-1:0]    g_idx, g_idx_nxt;
  logic                busy_nxt;
  logic [PTR_W-1:0]    rr_ptr, rr_nxt;
  logic [15:0]         drop_nxt;

  logic [N_PORTS-1:0]  cand;
  logic [N_PORTS-1:0]  drain;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [N_PORTS-1:0]  win_oh;

  logic [STREAM_W-1:0] data_a  [N_PORTS];
  logic [2:0]          empty_a [N_PORTS];

  // Saturating add of this cycle's drained-beat count onto the drop counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [CNT_W-1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Number of ports draining a beat this cycle.
  function automatic logic [CNT_W-1:0] count_ones(input logic [N_PORTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign data_a[p]  = s_data[p*STREAM_W +: STREAM_W];
    assign empty_a[p] = s_empty[p*3 +: 3];
  end

  assign cand  = s_valid & s_sop;
  assign drain = s_valid & ~s_sop;

  // Round-robin search: first SOP candidate at or after rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!win_found && cand[idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
    win_oh = N_PORTS'(1) << win_idx;
  end

  // Next-state, grant bookkeeping and the combinational stream mux.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_oh;
    g_idx_nxt = g_idx;
    busy_nxt  = busy;
    rr_nxt    = rr_ptr;
    drop_nxt  = drop_cnt;
    s_ready   = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_sop     = 1'b0;
    m_eop     = 1'b0;
    m_empty   = '0;
    case (state)
      IDLE: begin
        // SOP beats are held for the winner; anything else is thrown away.
        s_ready  = drain;
        drop_nxt = sat_add16(drop_cnt, count_ones(drain));
        if (win_found) begin
          state_nxt = LOCK;
          grant_nxt = win_oh;
          g_idx_nxt = win_idx;
          busy_nxt  = 1'b1;
        end
      end
      LOCK: begin
        m_valid        = s_valid[g_idx];
        m_data         = data_a[g_idx];
        m_sop          = s_sop[g_idx];
        m_eop          = s_eop[g_idx];
        m_empty        = empty_a[g_idx];
        s_ready[g_idx] = m_ready;
        if (s_valid[g_idx] && m_ready && s_eop[g_idx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          rr_nxt    = (g_idx == LAST_IDX) ? '0 : g_idx + PTR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_oh <= '0;
      g_idx    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_oh <= grant_nxt;
      g_idx    <= g_idx_nxt;
      busy     <= busy_nxt;
      rr_ptr   <= rr_nxt;
      drop_cnt <= drop_nxt;
    end
  end

`ifdef ITCH_FEED_ARB_PKT_CNT_EN
  logic        pkt_done;
  logic [31:0] pkt_q [N_PORTS];

  assign pkt_done = (state == LOCK) && s_valid[g_idx] && m_ready && s_eop[g_idx];

  // Per-port forwarded packet counters, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < N_PORTS; p++) pkt_q[p] <= '0;
    end else if (pkt_done) begin
      pkt_q[g_idx] <= pkt_q[g_idx] + 32'd1;
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_pkt_cnt
    assign pkt_cnt[p*32 +: 32] = pkt_q[p];
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_itch_feed_arb.sv
// Directed bench for itch_feed_arb with two ports: single packet, round-robin
// alternation, drain counting, owner stall, downstream backpressure and reset
// mid-packet.
module tb_itch_feed_arb;

  localparam int N = 2;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_valid, s_ready, s_sop, s_eop;
  logic [N*W-1:0] s_data;
  logic [N*3-1:0] s_empty;
  logic           m_valid, m_ready, m_sop, m_eop;
  logic [W-1:0]   m_data;
  logic [2:0]     m_empty;
  logic [N-1:0]   grant_oh;
  logic           busy;
  logic [15:0]    drop_cnt;
  logic [N*32-1:0] pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  itch_feed_arb #(.N_PORTS(N), .STREAM_W(W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sop(s_sop), .s_eop(s_eop), .s_empty(s_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .m_empty(m_empty),
    .grant_oh(grant_oh), .busy(busy), .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic sop, input logic eop,
                          input logic [63:0] d, input logic [2:0] e);
    s_valid[p]         = v;
    s_sop[p]           = sop;
    s_eop[p]           = eop;
    s_data[p*W +: W]   = d;
    s_empty[p*3 +: 3]  = e;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  function automatic logic [63:0] mk(input int p, input int k, input int b);
    return 64'hA5A5_0000_0000_0000 | 64'((p << 16) | (k << 8) | b);
  endfunction

  // Round-robin table: 12 cycles of both ports streaming 2-beat packets.
  logic [1:0] exp_g [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                             2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
  logic       exp_v [12] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  int         exp_p [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
  int         exp_k [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1};
  int         exp_b [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    int         beat [N];
    int         pkt  [N];
    logic [N-1:0] took;
    logic [63:0] exp_pc0;

    rst = 1'b1; m_ready = 1'b1;
    s_valid = '0; s_sop = '0; s_eop = '0; s_data = '0; s_empty = '0;
    step; step;
    rst = 1'b0;

    // Reset state
    mid;
    check("rst_grant", 64'(grant_oh), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mvalid", 64'(m_valid), 64'd0);
    check("rst_sready", 64'(s_ready), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_pkt", pkt_cnt[63:0], 64'd0);

    // Single 5-beat packet from port 0
    step;
    set_port(0, 1, 1, 0, 64'h1111_0000_0000_0000, 3'd0);
    mid;
    check("p1_arb_sready", 64'(s_ready), 64'd0);
    check("p1_arb_mvalid", 64'(m_valid), 64'd0);
    step;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) set_port(0, 1, 0, (i == 4), 64'h1111_0000_0000_0000 + 64'(i), (i == 4) ? 3'd3 : 3'd0);
      mid;
      check("p1_grant", 64'(grant_oh), 64'd1);
      check("p1_data", m_data, 64'h1111_0000_0000_0000 + 64'(i));
      check("p1_eop", 64'(m_eop), 64'(i == 4));
      check("p1_sop", 64'(m_sop), 64'(i == 0));
      if (i == 4) check("p1_empty", 64'(m_empty), 64'd3);
      step;
    end
    set_port(0, 0, 0, 0, 64'd0, 3'd0);
    mid;
    check("p1_busy_off", 64'(busy), 64'd0);
    check("p1_grant_off", 64'(grant_oh), 64'd0);
`ifdef ITCH_FEED_ARB_PKT_CNT_EN
    exp_pc0 = 64'd1;
`else
    exp_pc0 = 64'd0;
`endif
    check("p1_pktcnt0", 64'(pkt_cnt[31:0]), exp_pc0);

    // Round robin with both ports streaming, starting from rr_ptr=0
    rst = 1'b1; step; rst = 1'b0;
    for (int p = 0; p < N; p++) begin beat[p] = 0; pkt[p] = 0; end
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < N; p++)
        set_port(p, 1, beat[p] == 0, beat[p] == 1, mk(p, pkt[p], beat[p]), 3'd0);
      mid;
      check("rr_grant", 64'(grant_oh), 64'(exp_g[c]));
      check("rr_mvalid", 64'(m_valid), 64'(exp_v[c]));
      if (exp_v[c]) check("rr_data", m_data, mk(exp_p[c], exp_k[c], exp_b[c]));
      took = s_ready & s_valid;
      step;
      for (int p = 0; p < N; p++) begin
        if (took[p]) begin
          beat[p]++;
          if (beat[p] == 2) begin beat[p] = 0; pkt[p]++; end
        end
      end
    end
    for (int p = 0; p < N; p++) set_port(p, 0, 0, 0, 64'd0, 3'd0);

    // Drain: port 1 non-SOP beats while idle
    for (int i = 0; i < 3; i++) begin
      set_port(1, 1, 0, 0, 64'hDEAD_0000 + 64'(i), 3'd0);
      mid;
      check("drn_sready", 64'(s_ready), 64'b10);
      check("drn_mvalid", 64'(m_valid), 64'd0);
      check("drn_cnt_run", 64'(drop_cnt), 64'(i));
      step;
    end
    set_port(1, 0, 0, 0, 64'd0, 3'd0);
    mid;
    check("drn_cnt", 64'(drop_cnt), 64'd3);

    // Owner stalls mid-packet while port 1 offers an SOP
    step;
    set_port(0, 1, 1, 0, 64'h2222_0000, 3'd0);
    step;
    mid;
    check("stl_grant0", 64'(grant_oh), 64'b01);
    step;
    set_port(0, 0, 0, 0, 64'd0, 3'd0);
    set_port(1, 1, 1, 1, 64'h3333_0000, 3'd5);
    for (int i = 0; i < 4; i++) begin
      mid;
      check("stl_grant", 64'(grant_oh), 64'b01);
      check("stl_sready1", 64'(s_ready[1]), 64'd0);
      check("stl_mvalid", 64'(m_valid), 64'd0);
      step;
    end
    set_port(0, 1, 0, 1, 64'h2222_0001, 3'd2);
    mid;
    check("stl_eop", 64'(m_eop), 64'd1);
    check("stl_eop_data", m_data, 64'h2222_0001);
    check("stl_sready1b", 64'(s_ready[1]), 64'd0);
    step;
    set_port(0, 0, 0, 0, 64'd0, 3'd0);
    mid;
    check("stl_idle", 64'(grant_oh), 64'd0);
    check("stl_hold_sop", 64'(s_ready[1]), 64'd0);
    step;
    mid;
    check("stl_grant1", 64'(grant_oh), 64'b10);
    check("stl_p1_data", m_data, 64'h3333_0000);
    check("stl_p1_empty", 64'(m_empty), 64'd5);
    step;
    set_port(1, 0, 0, 0, 64'd0, 3'd0);

    // Downstream backpressure for 10 cycles mid-packet
    set_port(0, 1, 1, 0, 64'h4444_0000, 3'd0);
    step;
    step;
    set_port(0, 1, 0, 0, 64'h4444_0001, 3'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid;
      check("bp_sready", 64'(s_ready), 64'd0);
      check("bp_data", m_data, 64'h4444_0001);
      check("bp_mvalid", 64'(m_valid), 64'd1);
      step;
    end
    m_ready = 1'b1;
    mid;
    check("bp_resume", 64'(s_ready), 64'b01);
    step;
    set_port(0, 1, 0, 1, 64'h4444_0002, 3'd1);
    mid;
    check("bp_last", m_data, 64'h4444_0002);
    check("bp_last_eop", 64'(m_eop), 64'd1);
    step;
    set_port(0, 0, 0, 0, 64'd0, 3'd0);
    mid;
    check("bp_done", 64'(busy), 64'd0);

    // Reset pulse during beat 2 of a packet
    step;
    set_port(0, 1, 1, 0, 64'h5555_0000, 3'd0);
    step;
    step;
    set_port(0, 1, 0, 0, 64'h5555_0001, 3'd0);
    mid;
    check("rp_beat2", m_data, 64'h5555_0001);
    rst = 1'b1;
    step;
    rst = 1'b0;
    set_port(0, 0, 0, 0, 64'd0, 3'd0);
    mid;
    check("rp_grant", 64'(grant_oh), 64'd0);
    check("rp_busy", 64'(busy), 64'd0);
    check("rp_mvalid", 64'(m_valid), 64'd0);
    step;
    set_port(1, 1, 1, 1, 64'h6666_0000, 3'd0);
    step;
    mid;
    check("rp_grant1", 64'(grant_oh), 64'b10);
    check("rp_p1_sop", 64'(m_sop), 64'd1);
    check("rp_p1_data", m_data, 64'h6666_0000);
    step;
    set_port(1, 0, 0, 0, 64'd0, 3'd0);
    mid;
    check("rp_end", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/itch_feed_arb.md
Name: itch_feed_arb

Overview:
Packet-atomic round-robin arbiter that merges N Avalon-ST ITCH feed streams (e.g. A/B feed lines, or multiple exchange sessions) onto the single 64-bit Avalon-ST input of itch_parser. A grant is won only at a start-of-packet beat and held until the end-of-packet beat is accepted downstream, so messages never interleave. Garbage beats from non-owning ports are drained and counted.

Parameters:
N_PORTS, 2, number of upstream feed ports (2..8)
STREAM_W, 64, data width per port in bits (8 bytes per beat)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_valid  in  N_PORTS  per-port beat valid
s_ready  out  N_PORTS  per-port ready
s_data  in  N_PORTS*STREAM_W  per-port data; port p at [p*STREAM_W +: STREAM_W]
s_sop  in  N_PORTS  per-port start of packet
s_eop  in  N_PORTS  per-port end of packet
s_empty  in  N_PORTS*3  per-port empty byte count, port p at [p*3 +: 3]
m_valid  out  1  merged beat valid (to itch_parser s_valid)
m_ready  in  1  downstream ready (from itch_parser s_ready)
m_data  out  STREAM_W  merged data
m_sop  out  1  merged start of packet
m_eop  out  1  merged end of packet
m_empty  out  3  merged empty count
grant_oh  out  N_PORTS  one-hot current owner, 0 when idle
busy  out  1  1 while a packet is locked
drop_cnt  out  16  saturating count of drained non-SOP beats
pkt_cnt  out  N_PORTS*32  per-port forwarded packet count (optional feature)

Behaviour:
- Single clock domain; rst is synchronous and active-high.
- Reset values: state=IDLE, grant_oh=0, busy=0, rr_ptr=0, drop_cnt=0, pkt_cnt=0; m_valid=0 and s_ready=0 follow combinationally from IDLE.
- FSM states: IDLE, LOCK.
- IDLE:
  - m_valid=0.
  - Candidates are ports with s_valid&&s_sop. Winner = first candidate at or after rr_ptr, searching upward modulo N_PORTS.
  - If any candidate exists: register grant_oh=winner, busy=1, next state LOCK. The SOP beat is not consumed in this cycle (s_ready=0 for the winner), giving one bubble of arbitration latency.
  - Ports with s_valid&&!s_sop get s_ready=1; the beat is dropped and drop_cnt increments by 1, saturating at 0xFFFF (multiple drops in one cycle add 1 per port).
- LOCK, owner g:
  - Combinational pass-through: m_valid=s_valid[g], m_data/sop/eop/empty = port g's signals, s_ready[g]=m_ready.
  - All other ports: s_ready=0, no drain.
  - Transfer happens when m_valid&&m_ready.
  - On a transfer with m_eop=1: next state IDLE, grant_oh=0, busy=0, rr_ptr=(g+1) mod N_PORTS, pkt_cnt[g]++ (32-bit wrap).
  - A single-beat packet (sop&&eop) behaves the same; back-to-back packets are separated by one idle cycle.
  - A further s_sop on the owner mid-packet is forwarded unchanged; no checking is done.
- m_empty is meaningful only when m_eop=1; it is passed through unmodified.
- The owner holds the grant indefinitely while s_valid is low mid-packet; there is no timeout.
- Reset mid-packet: the FSM returns to IDLE on the next edge. Downstream sees a truncated packet; itch_parser shares rst and is reset in the same cycle.
- Fairness: with all ports continuously offering packets, grants rotate 0,1,..,N-1,0.

Optional Feature:
- Macro: ITCH_FEED_ARB_PKT_CNT_EN.
- Defined: pkt_cnt is maintained as described, one 32-bit wrapping counter per port, reset to 0.
- Undefined: no counter registers are built; pkt_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- Port0 sends a 5-beat packet, last beat s_empty=3, m_ready=1 → grant_oh=01 one cycle after the SOP is offered; 5 beats appear on m_* in order with m_eop/m_empty=3 on beat 5; busy drops the next cycle; pkt_cnt[0]=1.
- Both ports present SOP continuously with 2-beat packets, rr_ptr=0 → grant order 0,1,0,1; each packet's beats are contiguous with no interleaving; one idle cycle between packets.
- Port1 asserts s_valid with s_sop=0 for 3 cycles while IDLE → s_ready[1]=1 on those cycles, m_valid=0, drop_cnt=3.
- Owner deasserts s_valid for 4 cycles mid-packet while port1 offers a SOP → grant_oh is unchanged and s_ready[1]=0 throughout; port1 is granted only after the owner's EOP.
- m_ready=0 for 10 cycles mid-packet → s_ready[g]=0 and m_data stable; the packet completes intact after m_ready returns.
- rst pulsed for 1 cycle during beat 2 of a packet → grant_oh=0, busy=0, m_valid=0 next cycle; a new SOP from port1 is granted normally afterwards.
